mem_bist_ctrl: RTL and testbench
================================

Name: mem_bist_ctrl

Overview:
Built-in self-test sequencer for the single-port memories (synchronous and asynchronous variants) in the memory block. On a start pulse it takes ownership of the memory port and runs a 4-phase March sequence: write up, read/verify up, write-inverse down, read/verify down. It reports pass/fail, the error count and the first failing address. It sits between the memory instance and the system-side mux that hands the port to BIST or to normal traffic.

Parameters:
WIDTH, 8, memory data width in bits
DEPTH, 4, address width in bits; N = 1<<DEPTH words
RD_LAT, 1, memory read latency in cycles; 1 = synchronous memory, 0 = asynchronous memory; only 0 or 1 is legal
SEED, 8'hA5, WIDTH-bit base data pattern

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  single-cycle request to begin a test; sampled in IDLE or DONE only
busy  out  1  high while a test is running (any state except IDLE and DONE)
done  out  1  one-cycle pulse on the cycle the controller enters DONE
pass  out  1  valid from done onward; held until the next accepted start
err_cnt  out  DEPTH+2  mismatch count for the current/last run
fail_addr  out  DEPTH  address of the first mismatch; 0 if there was none
mem_we  out  1  memory write enable
mem_addr  out  DEPTH  memory address
mem_wrData  out  WIDTH  memory write data
mem_rdData  in  WIDTH  memory read data

Behaviour:
- Reset (asynchronous): state=IDLE; busy=0, done=0, pass=0, err_cnt=0, fail_addr=0, mem_we=0, mem_addr=0, mem_wrData=0.
- Pattern: P(a) = SEED ^ zero-extended a, truncated to WIDTH. Phase W0 writes P(a); phase W1 writes ~P(a).
- States:
  - IDLE/DONE: start=1 -> W0_UP. Counters, err_cnt, fail_addr and pass all clear on this transition.
  - W0_UP: mem_we=1, addr 0..N-1, one address per cycle. After address N-1 -> R0_UP.
  - R0_UP: mem_we=0, addr 0..N-1, then RD_LAT drain cycles. Expected data is P(a). After the last compare -> W1_DN.
  - W1_DN: mem_we=1, addr N-1 down to 0, data ~P(a). After address 0 -> R1_DN.
  - R1_DN: mem_we=0, addr N-1 down to 0, plus RD_LAT drain cycles. Expected data is ~P(a). After the last compare -> DONE.
- Outputs are registered: mem_we, mem_addr and mem_wrData change only on clk edges.
- Read compare: mem_rdData is compared against the expectation for the address issued RD_LAT cycles earlier. The address and expected data travel in a RD_LAT-deep pipeline. During drain cycles, mem_addr holds the last address and mem_we=0.
- Mismatch handling:
  - err_cnt increments by 1 per mismatching word. The maximum is 2N, so the counter cannot overflow; no saturation logic is needed.
  - fail_addr latches only on the first mismatch of a run.
- Latency: exactly 4N + 2*RD_LAT cycles from the start-sampling edge to the DONE entry edge. For defaults this is 66.
- DONE entry: done pulses, pass = (err_cnt==0 including the final compare), busy drops. DONE behaves like IDLE for start; no return to IDLE is required.
- start while busy: ignored with no effect.
- Reset mid-run: immediate return to IDLE with all outputs at reset values. The memory contents are left undefined, which is acceptable.
- Address counter wraps never escape: the counter is DEPTH+1 bits wide, or terminal-detect is on N-1 / 0, so no extra write occurs past either end.

Decomposition:
- Package mem_bist_pkg: state enum (IDLE, W0_UP, R0_UP, W1_DN, R1_DN, DONE) and a pattern function P(a, SEED).
- One sub-module, mem_bist_cmp: RD_LAT-deep expected-data/address pipeline plus comparator, err_cnt and fail_addr capture.

Test Plan:
- Fault-free Sync_mem_struct, defaults, start at cycle 3:
  - mem_we high for 16 cycles with addr 0..15 and wrData 0xA5..0xAA as P(a).
  - done exactly 66 cycles after start; pass=1, err_cnt=0, fail_addr=0.
- Memory model with addr 5 bit0 stuck-at-1:
  - R0 reads 0xA1 vs 0xA0, a mismatch; R1 matches.
  - Result: pass=0, err_cnt=1, fail_addr=5.
- Stuck-at-0 at bit7 of addr 3 and addr 9:
  - R0 mismatches at both (P has bit7=1); R1 matches.
  - Result: err_cnt=2, fail_addr=3 (the first failing address, not 9).
- start pulsed at cycles 10 and 40 during a run:
  - done still arrives 66 cycles after the first start.
  - err_cnt is unaffected and no restart occurs.
- rst asserted mid-R0_UP, then released and start pulsed:
  - Outputs go to reset values within the same cycle.
  - The new run completes in 66 cycles with pass=1.
- RD_LAT=0 with aSync_mem:
  - done 64 cycles after start; pass=1.
  - A second start immediately after done re-runs with err_cnt cleared.

Source files
------------

// File: rtl/mem_bist_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : mem_bist_pkg
// Brief    : Shared state encoding and data-pattern helper for the memory BIST.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package mem_bist_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      W0_UP = 3'd1,
      R0_UP = 3'd2,
      W1_DN = 3'd3,
      R1_DN = 3'd4,
      DONE  = 3'd5
   } bistState_t;

   // Widest supported pattern; callers truncate to their own data width.
   localparam int c_patMaxW = 64;

   function automatic logic [c_patMaxW-1:0] patternOf(
      input logic [c_patMaxW-1:0] seed,
      input logic [c_patMaxW-1:0] addr
   );
      return seed ^ addr;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_bist_cmp.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : mem_bist_cmp
// Brief    : Read-latency matched compare pipeline with error count and
//            first-failing-address capture.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module mem_bist_cmp
   import mem_bist_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int DEPTH  = 4,
   parameter int RD_LAT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             issueValid,
   input  logic [DEPTH-1:0] issueAddr,
   input  logic [WIDTH-1:0] issueExp,
   input  logic [WIDTH-1:0] rdData,
   output logic             mismatch,
   output logic [DEPTH+1:0] errCnt,
   output logic [DEPTH-1:0] failAddr
);

   logic             w_cmpValid;
   logic [DEPTH-1:0] w_cmpAddr;
   logic [WIDTH-1:0] w_cmpExp;
   logic [DEPTH+1:0] r_errCnt;
   logic [DEPTH-1:0] r_failAddr;

   generate
      if (RD_LAT == 0) begin : g_lat0
         assign w_cmpValid = issueValid;
         assign w_cmpAddr  = issueAddr;
         assign w_cmpExp   = issueExp;
      end else begin : g_latN
         logic             r_pipeValid [RD_LAT];
         logic [DEPTH-1:0] r_pipeAddr  [RD_LAT];
         logic [WIDTH-1:0] r_pipeExp   [RD_LAT];

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int i = 0; i < RD_LAT; i++) begin
                  r_pipeValid[i] <= 1'b0;
                  r_pipeAddr[i]  <= '0;
                  r_pipeExp[i]   <= '0;
               end
            end else begin
               r_pipeValid[0] <= issueValid;
               r_pipeAddr[0]  <= issueAddr;
               r_pipeExp[0]   <= issueExp;
               for (int i = 1; i < RD_LAT; i++) begin
                  r_pipeValid[i] <= r_pipeValid[i-1];
                  r_pipeAddr[i]  <= r_pipeAddr[i-1];
                  r_pipeExp[i]   <= r_pipeExp[i-1];
               end
            end
         end

         assign w_cmpValid = r_pipeValid[RD_LAT-1];
         assign w_cmpAddr  = r_pipeAddr[RD_LAT-1];
         assign w_cmpExp   = r_pipeExp[RD_LAT-1];
      end
   endgenerate

   assign mismatch = w_cmpValid && (rdData != w_cmpExp);

   // The count is sized for 2N errors, so a plain increment never wraps.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_errCnt   <= '0;
         r_failAddr <= '0;
      end else if (clr) begin
         r_errCnt   <= '0;
         r_failAddr <= '0;
      end else if (mismatch) begin
         r_errCnt <= r_errCnt + 1'b1;
         if (r_errCnt == '0) begin
            r_failAddr <= w_cmpAddr;
         end
      end
   end

   assign errCnt   = r_errCnt;
   assign failAddr = r_failAddr;

endmodule
`default_nettype wire

// File: rtl/mem_bist_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : mem_bist_ctrl
// Brief    : Four-phase March BIST sequencer for single-port memories.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module mem_bist_ctrl
   import mem_bist_pkg::*;
#(
   parameter int               WIDTH  = 8,
   parameter int               DEPTH  = 4,
   parameter int               RD_LAT = 1,
   parameter logic [WIDTH-1:0] SEED   = 8'hA5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [DEPTH+1:0] err_cnt,
   output logic [DEPTH-1:0] fail_addr,
   output logic             mem_we,
   output logic [DEPTH-1:0] mem_addr,
   output logic [WIDTH-1:0] mem_wrData,
   input  logic [WIDTH-1:0] mem_rdData
);

   localparam int             c_n       = 1 << DEPTH;
   localparam logic [DEPTH:0] c_lastW   = (DEPTH+1)'(c_n - 1);
   localparam logic [DEPTH:0] c_lastR   = (DEPTH+1)'(c_n - 1 + RD_LAT);
   localparam logic [DEPTH-1:0] c_topAddr = DEPTH'(c_n - 1);

   bistState_t       r_state;
   bistState_t       w_nextState;
   logic [DEPTH:0]   r_cnt;
   logic [DEPTH:0]   w_nextCnt;
   logic             w_clr;
   logic             w_doneEntry;

   logic [DEPTH-1:0] w_addrUp;
   logic [DEPTH-1:0] w_addrDn;
   logic             w_nextWe;
   logic [DEPTH-1:0] w_nextAddr;
   logic [WIDTH-1:0] w_nextWrData;
   logic             w_nextRdValid;
   logic [WIDTH-1:0] w_nextExp;

   logic             r_memWe;
   logic [DEPTH-1:0] r_memAddr;
   logic [WIDTH-1:0] r_memWrData;
   logic             r_rdValid;
   logic [WIDTH-1:0] r_expData;
   logic             r_done;
   logic             r_pass;

   logic             w_mismatch;
   logic [DEPTH+1:0] w_errCnt;
   logic [DEPTH-1:0] w_failAddr;

   function automatic logic [WIDTH-1:0] patOf(input logic [DEPTH-1:0] a);
      return WIDTH'(patternOf(c_patMaxW'(SEED), c_patMaxW'(a)));
   endfunction

   // Phase counter runs N cycles for writes and N+RD_LAT for reads (drain).
   always_comb begin
      w_nextState = r_state;
      w_nextCnt   = r_cnt;
      w_clr       = 1'b0;
      case (r_state)
         IDLE, DONE: begin
            if (start) begin
               w_nextState = W0_UP;
               w_nextCnt   = '0;
               w_clr       = 1'b1;
            end
         end
         W0_UP: begin
            if (r_cnt == c_lastW) begin
               w_nextState = R0_UP;
               w_nextCnt   = '0;
            end else begin
               w_nextCnt = r_cnt + 1'b1;
            end
         end
         R0_UP: begin
            if (r_cnt == c_lastR) begin
               w_nextState = W1_DN;
               w_nextCnt   = '0;
            end else begin
               w_nextCnt = r_cnt + 1'b1;
            end
         end
         W1_DN: begin
            if (r_cnt == c_lastW) begin
               w_nextState = R1_DN;
               w_nextCnt   = '0;
            end else begin
               w_nextCnt = r_cnt + 1'b1;
            end
         end
         R1_DN: begin
            if (r_cnt == c_lastR) begin
               w_nextState = DONE;
               w_nextCnt   = '0;
            end else begin
               w_nextCnt = r_cnt + 1'b1;
            end
         end
         default: begin
            w_nextState = IDLE;
            w_nextCnt   = '0;
         end
      endcase
   end

   // Drain cycles clamp to the last address, so the port holds it steady.
   assign w_addrUp    = (w_nextCnt > c_lastW) ? c_topAddr : w_nextCnt[DEPTH-1:0];
   assign w_addrDn    = ~w_addrUp;
   assign w_doneEntry = (r_state == R1_DN) && (w_nextState == DONE);

   always_comb begin
      w_nextWe      = 1'b0;
      w_nextAddr    = '0;
      w_nextWrData  = '0;
      w_nextRdValid = 1'b0;
      w_nextExp     = '0;
      case (w_nextState)
         W0_UP: begin
            w_nextWe     = 1'b1;
            w_nextAddr   = w_addrUp;
            w_nextWrData = patOf(w_addrUp);
         end
         R0_UP: begin
            w_nextAddr    = w_addrUp;
            w_nextRdValid = (w_nextCnt <= c_lastW);
            w_nextExp     = patOf(w_addrUp);
         end
         W1_DN: begin
            w_nextWe     = 1'b1;
            w_nextAddr   = w_addrDn;
            w_nextWrData = ~patOf(w_addrDn);
         end
         R1_DN: begin
            w_nextAddr    = w_addrDn;
            w_nextRdValid = (w_nextCnt <= c_lastW);
            w_nextExp     = ~patOf(w_addrDn);
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_memWe     <= 1'b0;
         r_memAddr   <= '0;
         r_memWrData <= '0;
         r_rdValid   <= 1'b0;
         r_expData   <= '0;
         r_done      <= 1'b0;
         r_pass      <= 1'b0;
      end else begin
         r_state     <= w_nextState;
         r_cnt       <= w_nextCnt;
         r_memWe     <= w_nextWe;
         r_memAddr   <= w_nextAddr;
         r_memWrData <= w_nextWrData;
         r_rdValid   <= w_nextRdValid;
         r_expData   <= w_nextExp;
         r_done      <= w_doneEntry;
         // The final compare lands on the DONE-entry edge, so fold it in here.
         if (w_clr) begin
            r_pass <= 1'b0;
         end else if (w_doneEntry) begin
            r_pass <= (w_errCnt == '0) && !w_mismatch;
         end
      end
   end

   mem_bist_cmp #(
      .WIDTH  (WIDTH),
      .DEPTH  (DEPTH),
      .RD_LAT (RD_LAT)
   ) u_cmp (
      .clk        (clk),
      .rst        (rst),
      .clr        (w_clr),
      .issueValid (r_rdValid),
      .issueAddr  (r_memAddr),
      .issueExp   (r_expData),
      .rdData     (mem_rdData),
      .mismatch   (w_mismatch),
      .errCnt     (w_errCnt),
      .failAddr   (w_failAddr)
   );

   assign busy       = (r_state != IDLE) && (r_state != DONE);
   assign done       = r_done;
   assign pass       = r_pass;
   assign err_cnt    = w_errCnt;
   assign fail_addr  = w_failAddr;
   assign mem_we     = r_memWe;
   assign mem_addr   = r_memAddr;
   assign mem_wrData = r_memWrData;

endmodule
`default_nettype wire

// File: tb/tb_mem_bist_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_mem_bist_ctrl
// Brief    : Scoreboard bench for mem_bist_ctrl (sync and async memory models).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_mem_bist_ctrl;

   localparam int         WIDTH = 8;
   localparam int         DEPTH = 4;
   localparam int         N     = 16;
   localparam logic [7:0] SEED  = 8'hA5;

   typedef struct {
      int         dut;
      logic [3:0] addr;
      logic [7:0] data;
   } wrRec_t;

   typedef struct {
      int          dut;
      int unsigned doneCyc;
      logic        pass;
      logic [5:0]  errCnt;
      logic [3:0]  failAddr;
   } resRec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int unsigned cyc = 0;

   logic       start     [2];
   logic       busy      [2];
   logic       done      [2];
   logic       pass      [2];
   logic       memWe     [2];
   logic [5:0] errCnt    [2];
   logic [3:0] failAddr  [2];
   logic [3:0] memAddr   [2];
   logic [7:0] memWrData [2];
   logic [7:0] sa1Mask   [N];
   logic [7:0] sa0Mask   [N];

   wrRec_t  wrQ[$];
   resRec_t resQ[$];
   int      nChecks = 0;
   int      nFails  = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Instance 0 sees a synchronous memory, instance 1 an asynchronous one.
   generate
      for (genvar g = 0; g < 2; g++) begin : g_dut
         localparam int LAT = (g == 0) ? 1 : 0;
         logic [7:0] mem [N];
         logic [7:0] rdData;

         mem_bist_ctrl #(
            .WIDTH  (WIDTH),
            .DEPTH  (DEPTH),
            .RD_LAT (LAT),
            .SEED   (SEED)
         ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .start      (start[g]),
            .busy       (busy[g]),
            .done       (done[g]),
            .pass       (pass[g]),
            .err_cnt    (errCnt[g]),
            .fail_addr  (failAddr[g]),
            .mem_we     (memWe[g]),
            .mem_addr   (memAddr[g]),
            .mem_wrData (memWrData[g]),
            .mem_rdData (rdData)
         );

         always @(posedge clk)
            if (memWe[g])
               mem[memAddr[g]] <= (memWrData[g] | sa1Mask[memAddr[g]]) & ~sa0Mask[memAddr[g]];

         if (LAT == 1) begin : g_syncMem
            always @(posedge clk) rdData <= mem[memAddr[g]];
         end else begin : g_asyncMem
            assign rdData = mem[memAddr[g]];
         end
      end
   endgenerate

   task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      if (got !== exp) begin
         nFails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] pat(input int a);
      return SEED ^ 8'(a);
   endfunction

   function automatic logic [7:0] stored(input int a, input logic [7:0] d);
      return (d | sa1Mask[a]) & ~sa0Mask[a];
   endfunction

   // Monitor: every observed write and every done pulse consumes one record.
   always @(negedge clk) begin
      wrRec_t  w;
      resRec_t r;
      if (!rst) begin
         for (int k = 0; k < 2; k++) begin
            if (memWe[k]) begin
               checkEq("wr_expected", 32'(wrQ.size() != 0), 32'd1);
               if (wrQ.size() != 0) begin
                  w = wrQ.pop_front();
                  checkEq("wr_dut", 32'(k), 32'(w.dut));
                  checkEq("wr_addr", 32'(memAddr[k]), 32'(w.addr));
                  checkEq("wr_data", 32'(memWrData[k]), 32'(w.data));
               end
            end
            if (done[k]) begin
               checkEq("done_expected", 32'(resQ.size() != 0), 32'd1);
               if (resQ.size() != 0) begin
                  r = resQ.pop_front();
                  checkEq("done_dut", 32'(k), 32'(r.dut));
                  checkEq("done_cycle", cyc, r.doneCyc);
                  checkEq("done_busy", 32'(busy[k]), 32'd0);
                  checkEq("done_pass", 32'(pass[k]), 32'(r.pass));
                  checkEq("done_err_cnt", 32'(errCnt[k]), 32'(r.errCnt));
                  checkEq("done_fail_addr", 32'(failAddr[k]), 32'(r.failAddr));
               end
            end
         end
      end
   end

   // Predicts the outcome from the fault masks, pushes records, pulses start.
   task automatic launch(input int k);
      resRec_t    r;
      wrRec_t     w;
      int         lat;
      int         errs;
      logic [3:0] fa;
      lat  = (k == 0) ? 1 : 0;
      errs = 0;
      fa   = '0;
      for (int a = 0; a < N; a++)
         if (stored(a, pat(a)) != pat(a)) begin
            if (errs == 0) fa = 4'(a);
            errs++;
         end
      for (int a = N - 1; a >= 0; a--)
         if (stored(a, ~pat(a)) != ~pat(a)) begin
            if (errs == 0) fa = 4'(a);
            errs++;
         end
      @(posedge clk); #1;
      start[k] = 1'b1;
      for (int a = 0; a < N; a++) begin
         w = '{dut: k, addr: 4'(a), data: pat(a)};
         wrQ.push_back(w);
      end
      for (int a = N - 1; a >= 0; a--) begin
         w = '{dut: k, addr: 4'(a), data: ~pat(a)};
         wrQ.push_back(w);
      end
      r = '{dut: k, doneCyc: cyc + 1 + 4 * N + 2 * lat, pass: (errs == 0),
            errCnt: 6'(errs), failAddr: fa};
      resQ.push_back(r);
      @(posedge clk); #1;
      start[k] = 1'b0;
      checkEq("busy_after_start", 32'(busy[k]), 32'd1);
   endtask

   task automatic awaitDone(input int k, input int budget);
      int n = 0;
      while (!done[k] && n < budget) begin
         @(negedge clk);
         n++;
      end
      checkEq("done_in_budget", 32'(done[k]), 32'd1);
      checkEq("wr_queue_drained", 32'(wrQ.size()), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      start[0] = 1'b0;
      start[1] = 1'b0;
      for (int a = 0; a < N; a++) begin
         sa1Mask[a] = '0;
         sa0Mask[a] = '0;
      end
      repeat (2) @(posedge clk);
      #1;
      checkEq("rst_busy", 32'(busy[0]), 32'd0);
      checkEq("rst_done", 32'(done[0]), 32'd0);
      checkEq("rst_pass", 32'(pass[0]), 32'd0);
      checkEq("rst_err_cnt", 32'(errCnt[0]), 32'd0);
      checkEq("rst_fail_addr", 32'(failAddr[0]), 32'd0);
      checkEq("rst_we", 32'(memWe[0]), 32'd0);
      checkEq("rst_addr", 32'(memAddr[0]), 32'd0);
      checkEq("rst_wrdata", 32'(memWrData[0]), 32'd0);
      rst = 1'b0;

      // Fault-free sync memory.
      launch(0);
      awaitDone(0, 100);
      repeat (3) @(negedge clk);
      checkEq("pass_hold", 32'(pass[0]), 32'd1);

      // Stuck-at-1 bit0 at address 5.
      sa1Mask[5] = 8'h01;
      launch(0);
      awaitDone(0, 100);
      sa1Mask[5] = 8'h00;

      // Stuck-at-0 bit7 at addresses 3 and 9.
      sa0Mask[3] = 8'h80;
      sa0Mask[9] = 8'h80;
      launch(0);
      awaitDone(0, 100);
      sa0Mask[3] = 8'h00;
      sa0Mask[9] = 8'h00;

      // Extra start pulses while busy must be ignored.
      sa1Mask[5] = 8'h01;
      launch(0);
      repeat (6) @(posedge clk);
      #1 start[0] = 1'b1;
      @(posedge clk); #1 start[0] = 1'b0;
      repeat (29) @(posedge clk);
      #1 start[0] = 1'b1;
      @(posedge clk); #1 start[0] = 1'b0;
      awaitDone(0, 100);

      // Reset in the middle of R0_UP, after the address-5 error is counted.
      launch(0);
      repeat (24) @(posedge clk);
      #1;
      checkEq("pre_rst_err_cnt", 32'(errCnt[0]), 32'd1);
      #2 rst = 1'b1;
      #1;
      checkEq("midrst_busy", 32'(busy[0]), 32'd0);
      checkEq("midrst_we", 32'(memWe[0]), 32'd0);
      checkEq("midrst_addr", 32'(memAddr[0]), 32'd0);
      checkEq("midrst_wrdata", 32'(memWrData[0]), 32'd0);
      checkEq("midrst_err_cnt", 32'(errCnt[0]), 32'd0);
      checkEq("midrst_fail_addr", 32'(failAddr[0]), 32'd0);
      wrQ.delete();
      resQ.delete();
      @(posedge clk); #1 rst = 1'b0;
      sa1Mask[5] = 8'h00;
      launch(0);
      awaitDone(0, 100);

      // Async memory: faulty run, then an immediate clean re-run.
      sa1Mask[5] = 8'h01;
      launch(1);
      awaitDone(1, 100);
      sa1Mask[5] = 8'h00;
      launch(1);
      awaitDone(1, 100);

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
      $finish;
   end

endmodule
`default_nettype wire
